msp_frame_rx: RTL

- Byte-level MSP v1 frame receiver placed directly downstream of ttl_serial.
- Consumes the UART's rx_data/rx_valid strobe and locates frames of the form '$' 'M' dir len cmd payload[len] csum.
- Verifies the XOR checksum and holds one complete frame in an internal payload buffer until the host logic acknowledges it.
- Feeds the flight-controller command decoder.

---
 rtl/msp_frame_rx_if.sv | 33 +++
 rtl/msp_frame_rx.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/msp_frame_rx_if.sv
// Bus bundle between the MSP v1 frame receiver and its UART source / host consumer.
// The slave view belongs to the receiver; the master view belongs to whatever drives it.
interface msp_frame_rx_if #(
   parameter int MAX_PAYLOAD = 64
);
   localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          frame_pending;
   logic [7:0]    frame_dir;
   logic [7:0]    frame_cmd;
   logic [7:0]    frame_len;
   logic          frame_ack;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data;
   logic          err_csum;
   logic          err_len;
   logic          err_timeout;
   logic          overrun;

   modport slave (
      input  rx_data, rx_valid, frame_ack, rd_addr,
      output frame_pending, frame_dir, frame_cmd, frame_len, rd_data,
             err_csum, err_len, err_timeout, overrun
   );

   modport master (
      output rx_data, rx_valid, frame_ack, rd_addr,
      input  frame_pending, frame_dir, frame_cmd, frame_len, rd_data,
             err_csum, err_len, err_timeout, overrun
   );
endinterface

// File: rtl/msp_frame_rx.sv
// MSP v1 frame receiver: hunts for "$M<dir><len><cmd><payload><csum>" in the UART byte
// stream, checks the XOR checksum and holds one verified frame until the host acks it.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | hunting for '$'
// S_HDR_M   | '$' seen, expecting 'M' ('$' resyncs here)
// S_HDR_DIR | expecting direction byte '<', '>' or '!'
// S_LEN     | expecting payload length
// S_CMD     | expecting command byte
// S_PAYLOAD | receiving payload bytes into the buffer (when capturing)
// S_CSUM    | expecting checksum byte; frame completes or errors here
module msp_frame_rx #(
   parameter int MAX_PAYLOAD    = 64,
   parameter int TIMEOUT_CYCLES = 27000
) (
   input  logic            clk,
   input  logic            rst,
   msp_frame_rx_if.slave   bus
);
   localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [7:0] CH_DOLLAR = 8'h24;
   localparam logic [7:0] CH_M      = 8'h4D;
   localparam logic [7:0] CH_LT     = 8'h3C;
   localparam logic [7:0] CH_GT     = 8'h3E;
   localparam logic [7:0] CH_BANG   = 8'h21;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR_M,
      S_HDR_DIR,
      S_LEN,
      S_CMD,
      S_PAYLOAD,
      S_CSUM
   } state_t;

   state_t        state, state_nxt;

   logic [7:0]    mem [0:MAX_PAYLOAD-1];
   logic [7:0]    dir_r, len_r, cmd_r, csum, idx;
   logic [TW-1:0] tmo_cnt;
   logic          capture;

   logic          pending_q;
   logic [7:0]    frame_dir_q, frame_cmd_q, frame_len_q, rd_data_q;
   logic          err_csum_q, err_len_q, err_timeout_q, overrun_q;

   logic          set_capture, wr_en, done_ok;
   logic          csum_err_nxt, len_err_nxt, tmo_nxt;

   // Next-state and event decode
   always_comb begin
      state_nxt    = state;
      set_capture  = 1'b0;
      wr_en        = 1'b0;
      done_ok      = 1'b0;
      csum_err_nxt = 1'b0;
      len_err_nxt  = 1'b0;
      tmo_nxt      = 1'b0;

      if ((state != S_IDLE) && !bus.rx_valid &&
          (tmo_cnt == TW'(TIMEOUT_CYCLES - 1))) begin
         tmo_nxt   = 1'b1;
         state_nxt = S_IDLE;
      end else if (bus.rx_valid) begin
         case (state)
            S_IDLE: begin
               if (bus.rx_data == CH_DOLLAR) begin
                  state_nxt   = S_HDR_M;
                  set_capture = 1'b1;
               end
            end
            S_HDR_M: begin
               if (bus.rx_data == CH_M) begin
                  state_nxt = S_HDR_DIR;
               end else if (bus.rx_data == CH_DOLLAR) begin
                  state_nxt   = S_HDR_M;
                  set_capture = 1'b1;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
            S_HDR_DIR: begin
               if ((bus.rx_data == CH_LT) || (bus.rx_data == CH_GT) ||
                   (bus.rx_data == CH_BANG)) begin
                  state_nxt = S_LEN;
               end else if (bus.rx_data == CH_DOLLAR) begin
                  state_nxt   = S_HDR_M;
                  set_capture = 1'b1;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
            S_LEN: begin
               if (bus.rx_data > 8'(MAX_PAYLOAD)) begin
                  len_err_nxt = 1'b1;
                  state_nxt   = S_IDLE;
               end else begin
                  state_nxt = S_CMD;
               end
            end
            S_CMD: begin
               state_nxt = (len_r == 8'd0) ? S_CSUM : S_PAYLOAD;
            end
            S_PAYLOAD: begin
               wr_en = capture;
               if (idx == (len_r - 8'd1)) begin
                  state_nxt = S_CSUM;
               end
            end
            S_CSUM: begin
               if (bus.rx_data == csum) begin
                  done_ok = 1'b1;
               end else begin
                  csum_err_nxt = 1'b1;
               end
               state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         dir_r         <= 8'd0;
         len_r         <= 8'd0;
         cmd_r         <= 8'd0;
         csum          <= 8'd0;
         idx           <= 8'd0;
         tmo_cnt       <= '0;
         capture       <= 1'b0;
         pending_q     <= 1'b0;
         frame_dir_q   <= 8'd0;
         frame_cmd_q   <= 8'd0;
         frame_len_q   <= 8'd0;
         rd_data_q     <= 8'd0;
         err_csum_q    <= 1'b0;
         err_len_q     <= 1'b0;
         err_timeout_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state         <= state_nxt;
         err_csum_q    <= csum_err_nxt;
         err_len_q     <= len_err_nxt;
         err_timeout_q <= tmo_nxt;
         overrun_q     <= done_ok & ~capture;
         rd_data_q     <= mem[bus.rd_addr];

         if ((state == S_IDLE) || bus.rx_valid || tmo_nxt) begin
            tmo_cnt <= '0;
         end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
         end

         // Capture is decided at the '$' byte only; an ack mid-frame cannot enable it
         if (set_capture) begin
            capture <= ~pending_q;
         end else if (tmo_nxt) begin
            capture <= 1'b0;
         end

         if (bus.rx_valid) begin
            case (state)
               S_HDR_DIR: dir_r <= bus.rx_data;
               S_LEN: begin
                  len_r <= bus.rx_data;
                  csum  <= bus.rx_data;
               end
               S_CMD: begin
                  cmd_r <= bus.rx_data;
                  csum  <= csum ^ bus.rx_data;
                  idx   <= 8'd0;
               end
               S_PAYLOAD: begin
                  csum <= csum ^ bus.rx_data;
                  idx  <= idx + 8'd1;
               end
               default: ;
            endcase
         end

         // capture=1 implies nothing is held, so completion and ack never collide
         if (done_ok && capture) begin
            frame_dir_q <= dir_r;
            frame_cmd_q <= cmd_r;
            frame_len_q <= len_r;
            pending_q   <= 1'b1;
         end else if (bus.frame_ack && pending_q) begin
            pending_q <= 1'b0;
         end
      end
   end

   // Payload buffer has no reset; contents are only meaningful while a frame is held
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[idx[AW-1:0]] <= bus.rx_data;
      end
   end

   assign bus.frame_pending = pending_q;
   assign bus.frame_dir     = frame_dir_q;
   assign bus.frame_cmd     = frame_cmd_q;
   assign bus.frame_len     = frame_len_q;
   assign bus.rd_data       = rd_data_q;
   assign bus.err_csum      = err_csum_q;
   assign bus.err_len       = err_len_q;
   assign bus.err_timeout   = err_timeout_q;
   assign bus.overrun       = overrun_q;

endmodule
